// File: rtl/apb_slave_mem.sv
// APB4 completer backed by a DEPTH x 32-bit register memory with PSTRB lane writes.
// Optional macro APB_SLV_WAIT_EN enables the WAIT_STATES access-phase counter.
module apb_slave_mem #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic              PREADY,
  output logic [31:0]       PRDATA,
  output logic              PSLVERR
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ROW_W  = ADDR_W - 2;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ROW_W-1:0] DEPTH_ROW = ROW_W'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                capture_c;
  logic                access_c;
  logic                cnt_zero_c;
  logic                done_c;
  logic                err_c;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   strb_q;
  logic [ROW_W-1:0]    row_c;
  logic [IDX_W-1:0]    idx_c;
  logic [DATA_W-1:0]   mem [DEPTH];

  // Decode uses the captured address so mid-access bus changes are ignored
  assign row_c    = addr_q[ADDR_W-1:2];
  assign idx_c    = addr_q[IDX_W+1:2];
  assign err_c    = (addr_q[1:0] != 2'b00) || (row_c >= DEPTH_ROW);
  assign access_c = (state_q == ACCESS) && PSEL && PENABLE;
  assign done_c   = access_c && cnt_zero_c;

`ifdef APB_SLV_WAIT_EN
  logic [CNT_W-1:0] cnt_q;

  assign cnt_zero_c = (cnt_q == '0);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q <= '0;
    end else if (capture_c) begin
      cnt_q <= CNT_W'(WAIT_STATES);
    end else if (access_c && !cnt_zero_c) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_wait_states;

  assign unused_wait_states = CNT_W'(WAIT_STATES);
  assign cnt_zero_c         = 1'b1;
`endif

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a setup phase in ACCESS restarts the transfer
  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          capture_c = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_d = IDLE;
        end else if (!PENABLE) begin
          capture_c = 1'b1;
        end else if (cnt_zero_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus responses, only meaningful in the completing cycle
  always_comb begin
    PREADY  = done_c;
    PSLVERR = done_c && err_c;
    PRDATA  = '0;
    if (done_c && !write_q && !err_c) begin
      PRDATA = mem[idx_c];
    end
  end

  // Setup-phase capture of the transfer fields
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else if (capture_c) begin
      write_q <= PWRITE;
      addr_q  <= PADDR;
      wdata_q <= PWDATA;
      strb_q  <= PSTRB;
    end
  end

  // Byte-lane memory write on the completing edge of a valid write
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (done_c && write_q && !err_c) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (strb_q[b]) begin
          mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule
